// File: rtl/swt_debounce.sv
// rtl/swt_debounce.sv - per-bit synchronise and debounce of slide switches with edge pulses
// Edge outputs are built only when SWT_DEBOUNCE_EDGE_EN is defined; otherwise tied to 0.
module swt_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] swt_raw,
  output logic [WIDTH-1:0] swt,
  output logic [WIDTH-1:0] swt_rise,
  output logic [WIDTH-1:0] swt_fall,
  output logic             swt_changed
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_swt;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] w_accept;

  // A bit is accepted on the edge where its mismatch has persisted for the full window.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_accept[i] = (r_s2[i] != r_swt[i]) && (r_cnt[i] == LP_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_swt <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1 <= swt_raw;
      r_s2 <= r_s1;
      for (int i = 0; i < WIDTH; i++) begin
        if (r_s2[i] == r_swt[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_swt[i] <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign swt = r_swt;

`ifdef SWT_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_changed;

  // The accepted value is r_s2, so it alone decides the direction of the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_rise    <= w_accept & r_s2;
      r_fall    <= w_accept & ~r_s2;
      r_changed <= |w_accept;
    end
  end

  assign swt_rise    = r_rise;
  assign swt_fall    = r_fall;
  assign swt_changed = r_changed;
`else
  assign swt_rise    = '0;
  assign swt_fall    = '0;
  assign swt_changed = 1'b0;
`endif

endmodule

// File: tb/tb_swt_debounce.sv
// tb/tb_swt_debounce.sv - randomized and directed checks of swt_debounce against a window model
module tb_swt_debounce;

  localparam int W    = 8;
  localparam int D    = 4;
  localparam int HMAX = 8192;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] swt_raw = '0;
  logic [W-1:0] swt;
  logic [W-1:0] swt_rise;
  logic [W-1:0] swt_fall;
  logic         swt_changed;

  int checks   = 0;
  int failures = 0;

  // Model state: raw level seen by the synchroniser at each edge, and per-bit edge of the last accept/reset.
  logic [W-1:0] hist [HMAX];
  int           last_ev [W];
  int           n = -1;
  logic [W-1:0] m_swt  = '0;
  logic [W-1:0] m_rise = '0;
  logic [W-1:0] m_fall = '0;
  logic         m_chg  = 1'b0;

  swt_debounce #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(24)
  ) dut (
    .clk(clk),
    .rst(rst),
    .swt_raw(swt_raw),
    .swt(swt),
    .swt_rise(swt_rise),
    .swt_fall(swt_fall),
    .swt_changed(swt_changed)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h edge=%0d", tag, got, exp, n);
    end
  endtask

  // A change is taken at edge n when the level the debouncer sees (raw two edges earlier)
  // differed from the clean level on each of the last D edges since the previous accept or reset.
  function automatic logic seen_bit(input int idx, input int b);
    if (idx < 0) return 1'b0;
    return hist[idx][b];
  endfunction

  task automatic model_edge();
    logic [W-1:0] acc;
    logic         ok;
    n++;
    if (rst) begin
      hist[n] = '0;
      if (n > 0) hist[n-1] = '0;
      m_swt  = '0;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) last_ev[i] = n;
    end else begin
      hist[n] = swt_raw;
      acc = '0;
      for (int i = 0; i < W; i++) begin
        ok = (n - D >= last_ev[i]);
        for (int j = 0; j < D; j++) begin
          if (seen_bit(n - 2 - j, i) == m_swt[i]) ok = 1'b0;
        end
        acc[i] = ok;
        if (ok) last_ev[i] = n;
      end
`ifdef SWT_DEBOUNCE_EDGE_EN
      m_rise = acc & ~m_swt;
      m_fall = acc & m_swt;
`else
      m_rise = '0;
      m_fall = '0;
`endif
      m_swt = m_swt ^ acc;
    end
    m_chg = |(m_rise | m_fall);
  endtask

  task automatic tick(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_val("swt", 32'(swt), 32'(m_swt));
      check_val("swt_rise", 32'(swt_rise), 32'(m_rise));
      check_val("swt_fall", 32'(swt_fall), 32'(m_fall));
      check_val("swt_changed", 32'(swt_changed), 32'(m_chg));
    end
  endtask

  initial begin
    int p;
    logic [W-1:0] flips;

    rst = 1'b1; swt_raw = 8'h00;
    tick(2);
    rst = 1'b0;
    tick(10);

    swt_raw = 8'h01; tick(12);
    swt_raw = 8'h00; tick(12);

    swt_raw = 8'h08; tick(1);
    swt_raw = 8'h00; tick(1);
    swt_raw = 8'h08; tick(1);
    swt_raw = 8'h00; tick(1);
    swt_raw = 8'h08; tick(10);
    swt_raw = 8'h00; tick(10);

    swt_raw = 8'h08; tick(3);
    swt_raw = 8'h00; tick(10);

    rst = 1'b1; swt_raw = 8'hA5; tick(2);
    rst = 1'b0; tick(10);
    check_val("a5_level", 32'(swt), 32'h0000_00A5);
    swt_raw = 8'h00; tick(10);

    swt_raw = 8'h01; tick(3);
    rst = 1'b1; tick(1);
    rst = 1'b0; tick(12);
    swt_raw = 8'h00; tick(10);

    for (int seg = 0; seg < 40; seg++) begin
      p = $urandom_range(0, 4);
      for (int c = 0; c < 50; c++) begin
        flips = '0;
        for (int b = 0; b < W; b++) begin
          if ($urandom_range(0, 15) < p) flips[b] = 1'b1;
        end
        swt_raw = swt_raw ^ flips;
        rst = ($urandom_range(0, 199) == 0);
        tick(1);
      end
      rst = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
